// File: rtl/mod_counter_div.sv
// mod_counter_div: modulo-MODULUS up/down counter with sync clear/load,
// combinational terminal count for cascading digit stages, and a free-running
// even-ratio divider that produces a 50% duty strobe of period DIV in_clk cycles.
// The divider is independent of every counter control input.
// Legal parameters: 2 <= MODULUS <= 2**WIDTH, DIV even and >= 2.
module mod_counter_div #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIV     = 10
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             out_clk
);

  // Highest legal count; fits in WIDTH bits because MODULUS <= 2**WIDTH.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  // Divider phase runs 0..HALF-1; one extra bit of width is never needed.
  localparam int              HALF    = DIV / 2;
  localparam int              PH_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  // Counter state
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Divider state
  logic [PH_W-1:0]  phase_q;
  logic [PH_W-1:0]  phase_d;
  logic             oclk_q;
  logic             oclk_d;

  // Candidate next counts, selected by the priority mux below
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_ld;
  logic             at_top;
  logic             at_bottom;

  // Saturate an out-of-range load value to the highest legal count.
  // Comparison is done at 32 bits so MODULUS == 2**WIDTH stays well formed.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (32'(v) >= MODULUS) begin
      return CNT_MAX;
    end
    return v;
  endfunction

  // Up step with wrap; any value at or beyond the top (including a corrupted
  // out-of-range count) returns to 0.
  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    if (32'(v) >= MODULUS - 1) begin
      return '0;
    end
    return v + WIDTH'(1);
  endfunction

  // Down step with wrap; 0 and any out-of-range count go to the top value.
  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    if ((v == '0) || (32'(v) >= MODULUS)) begin
      return CNT_MAX;
    end
    return v - WIDTH'(1);
  endfunction

  // Precompute the step candidates and the wrap-point flags from current state
  always_comb begin
    cnt_inc   = inc_wrap(cnt_q);
    cnt_dec   = dec_wrap(cnt_q);
    cnt_ld    = clamp_load(load_val);
    at_top    = (cnt_q == CNT_MAX);
    at_bottom = (cnt_q == '0);
  end

  // Next count: clear beats load, load beats counting, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = cnt_ld;
    end else if (en) begin
      cnt_d = up_dn ? cnt_inc : cnt_dec;
    end
  end

  // Next divider phase: free-running, toggles the strobe once per half period
  always_comb begin
    phase_d = phase_q + PH_W'(1);
    oclk_d  = oclk_q;
    if (phase_q == PH_LAST) begin
      phase_d = '0;
      oclk_d  = ~oclk_q;
    end
  end

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Divider registers, cleared asynchronously by reset
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      oclk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      oclk_q  <= oclk_d;
    end
  end

  // Terminal count is combinational so the next stage sees it before the wrap
  // edge; deliberately not gated by clr/load, the cascade owner sequences those.
  always_comb begin
    tc = en & (up_dn ? at_top : at_bottom);
  end

  assign q       = cnt_q;
  assign out_clk = oclk_q;

endmodule

// File: tb/tb_mod_counter_div.sv
// Bench for mod_counter_div: a mod-10 units stage, a mod-10 tens stage chained
// from the units tc, and a full-range mod-16 / DIV=2 instance, all checked
// against a behavioural model through per-instance scoreboard queues.
module tb_mod_counter_div;

  logic       in_clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q_a, q_t, q_b;
  logic       tc_a, tc_t, tc_b;
  logic       out_clk_a, out_clk_t, out_clk_b;

  int total = 0;
  int bad   = 0;

  // model state
  int qa_m, qt_m, qb_m;
  int ph_a, ph_t, ph_b;
  int oc_a, oc_t, oc_b;
  int tens_pulses;

  int sb_a[$];
  int sb_t[$];
  int sb_b[$];

  mod_counter_div #(.WIDTH(4), .MODULUS(10), .DIV(10)) dut_a (
    .in_clk(in_clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .q(q_a), .tc(tc_a), .out_clk(out_clk_a)
  );

  mod_counter_div #(.WIDTH(4), .MODULUS(10), .DIV(10)) dut_t (
    .in_clk(in_clk), .rst(rst), .en(tc_a), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .q(q_t), .tc(tc_t), .out_clk(out_clk_t)
  );

  mod_counter_div #(.WIDTH(4), .MODULUS(16), .DIV(2)) dut_b (
    .in_clk(in_clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .q(q_b), .tc(tc_b), .out_clk(out_clk_b)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int qv, input logic e, input logic u, input logic c,
                             input logic l, input int lv, input int m);
    if (c) return 0;
    if (l) return (lv >= m) ? m - 1 : lv;
    if (!e) return qv;
    if (u) return (qv >= m - 1) ? 0 : qv + 1;
    return (qv == 0 || qv >= m) ? m - 1 : qv - 1;
  endfunction

  function automatic int tcm(input int qv, input logic e, input logic u, input int m);
    if (!e) return 0;
    return u ? int'(qv == m - 1) : int'(qv == 0);
  endfunction

  task automatic div_step(inout int ph, inout int oc, input int half);
    if (ph == half - 1) begin
      ph = 0;
      oc = 1 - oc;
    end else begin
      ph = ph + 1;
    end
  endtask

  task automatic model_reset();
    qa_m = 0; qt_m = 0; qb_m = 0;
    ph_a = 0; ph_t = 0; ph_b = 0;
    oc_a = 0; oc_t = 0; oc_b = 0;
  endtask

  // Drive one cycle of stimulus, check tc before the edge, predict and check
  // q and out_clk after it.
  task automatic tick(input logic e, input logic u, input logic c, input logic l,
                      input logic [3:0] lv);
    int ta;
    int tt;
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    #1;
    ta = tcm(qa_m, e, u, 10);
    tt = tcm(qt_m, ta[0], u, 10);
    chk("tc_a", {31'b0, tc_a}, ta);
    chk("tc_t", {31'b0, tc_t}, tt);
    chk("tc_b", {31'b0, tc_b}, tcm(qb_m, e, u, 16));
    if (tc_t) tens_pulses++;
    sb_a.push_back(nxt(qa_m, e, u, c, l, int'(lv), 10));
    sb_t.push_back(nxt(qt_m, ta[0], u, c, l, int'(lv), 10));
    sb_b.push_back(nxt(qb_m, e, u, c, l, int'(lv), 16));
    @(posedge in_clk);
    #1;
    qa_m = sb_a.pop_front();
    qt_m = sb_t.pop_front();
    qb_m = sb_b.pop_front();
    chk("q_a", {28'b0, q_a}, qa_m);
    chk("q_t", {28'b0, q_t}, qt_m);
    chk("q_b", {28'b0, q_b}, qb_m);
    div_step(ph_a, oc_a, 5);
    div_step(ph_t, oc_t, 5);
    div_step(ph_b, oc_b, 1);
    chk("oclk_a", {31'b0, out_clk_a}, oc_a);
    chk("oclk_t", {31'b0, out_clk_t}, oc_t);
    chk("oclk_b", {31'b0, out_clk_b}, oc_b);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    tens_pulses = 0;
    model_reset();

    // reset state
    #2;
    chk("rst_q_a", {28'b0, q_a}, 0);
    chk("rst_q_b", {28'b0, q_b}, 0);
    chk("rst_oclk_a", {31'b0, out_clk_a}, 0);
    chk("rst_oclk_b", {31'b0, out_clk_b}, 0);
    @(posedge in_clk);
    #1;
    chk("rst_hold_q_a", {28'b0, q_a}, 0);
    rst = 1'b1;

    // up count with wrap 0..9,0
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // down wrap from 0 -> 9 -> 8
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // priority: clear beats load, then clamped loads, then hold
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // mixed random traffic
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)));
    end

    // asynchronous reset mid-count, observed with no clock edge
    tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_q_a", {28'b0, q_a}, 0);
    chk("arst_q_t", {28'b0, q_t}, 0);
    chk("arst_q_b", {28'b0, q_b}, 0);
    chk("arst_oclk_a", {31'b0, out_clk_a}, 0);
    chk("arst_oclk_b", {31'b0, out_clk_b}, 0);
    model_reset();
    #1;
    rst = 1'b1;

    // cascade: 100 counting edges from 00 back to 00, one tens tc pulse
    tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tens_pulses = 0;
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("casc_units", {28'b0, q_a}, 0);
    chk("casc_tens", {28'b0, q_t}, 0);
    chk("casc_tc_pulses", tens_pulses, 1);

    // divider keeps running through en=0 and clr=1
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
